// File: rtl/trim_pkg.sv
// Shared types and width helpers for the trim code sweep generator.
package trim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCHS,
        HOLD
    } trim_state_t;

    function automatic int tick_cnt_w(input int div_max);
        return (div_max < 1) ? 1 : $clog2(div_max + 1);
    endfunction

    function automatic int bit_cnt_w(input int code_w);
        return $clog2(code_w + 1);
    endfunction

    // hold counter only needs to reach SETTLE_TICKS-1
    function automatic int hold_cnt_w(input int settle_ticks);
        return (settle_ticks < 2) ? 1 : $clog2(settle_ticks);
    endfunction

endpackage

// File: rtl/trim_tick_div.sv
// Enable-gated tick divider: one tick every DIV_MAX+1 cycles while enabled, held at zero otherwise.
module trim_tick_div
    import trim_pkg::*;
#(
    parameter int DIV_MAX = 24999999
) (
    input  logic CLK50,
    input  logic RST_N,
    input  logic en,
    output logic tick
);

    localparam int CW = tick_cnt_w(DIV_MAX);

    logic [CW-1:0] count_reg;
    logic          at_max;

    assign at_max = (count_reg == CW'(DIV_MAX));
    assign tick   = en && at_max;

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            count_reg <= '0;
        end else if (!en || at_max) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/trim_sweep_gen.sv
// Steps a trim code from START_CODE to END_CODE, shifts each code out serially,
// latches it and holds it for a settle window; all timing runs on CLK50 clock enables.
module trim_sweep_gen
    import trim_pkg::*;
#(
    parameter int CODE_W       = 12,
    parameter int DIV_MAX      = 24999999,
    parameter int START_CODE   = 1,
    parameter int END_CODE     = 4095,
    parameter int STEP         = 1,
    parameter int SETTLE_TICKS = 4,
    parameter int MSB_FIRST    = 0
) (
    input  logic              CLK50,
    input  logic              RST_N,
    input  logic              START,
    input  logic              ABORT,
    input  logic              SINGLE,
    output logic              DOUT,
    output logic              SCLK,
    output logic              LATCH,
    output logic [CODE_W-1:0] TRIMCODE,
    output logic              BUSY,
    output logic              DONE
);

    localparam int BW = bit_cnt_w(CODE_W);
    localparam int HW = hold_cnt_w(SETTLE_TICKS);

    trim_state_t       state_reg;
    logic [CODE_W-1:0] code_reg;
    logic [CODE_W-1:0] shreg_reg;
    logic [BW-1:0]     bit_cnt_reg;
    logic [HW-1:0]     hold_cnt_reg;
    logic              phase_reg;
    logic              single_reg;
    logic              dout_reg;
    logic              sclk_reg;
    logic              latch_reg;
    logic [CODE_W-1:0] trim_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              tick;
    logic              div_en;
    logic [CODE_W:0]   next_wide;
    logic [CODE_W-1:0] next_code;
    logic              out_bit;
    logic [CODE_W-1:0] shreg_next;
    logic              last_bit_sent;
    logic              last_hold_tick;
    logic              sweep_end;

    // Dropping the enable on ABORT clears the divider on the same edge that returns to IDLE.
    assign div_en = (state_reg != IDLE) && !ABORT;

    trim_tick_div #(
        .DIV_MAX(DIV_MAX)
    ) u_div (
        .CLK50(CLK50),
        .RST_N(RST_N),
        .en   (div_en),
        .tick (tick)
    );

    // One extra bit catches the carry so the last step clamps to END_CODE instead of wrapping.
    assign next_wide = {1'b0, code_reg} + (CODE_W+1)'(STEP);
    assign next_code = (next_wide > (CODE_W+1)'(END_CODE)) ? CODE_W'(END_CODE)
                                                           : next_wide[CODE_W-1:0];

    assign out_bit    = (MSB_FIRST != 0) ? shreg_reg[CODE_W-1] : shreg_reg[0];
    assign shreg_next = (MSB_FIRST != 0) ? {shreg_reg[CODE_W-2:0], 1'b0}
                                         : {1'b0, shreg_reg[CODE_W-1:1]};

    assign last_bit_sent  = (bit_cnt_reg == BW'(CODE_W));
    assign last_hold_tick = (hold_cnt_reg == HW'(SETTLE_TICKS - 1));
    assign sweep_end      = single_reg || (code_reg == CODE_W'(END_CODE));

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= IDLE;
            code_reg     <= '0;
            shreg_reg    <= '0;
            bit_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            phase_reg    <= 1'b0;
            single_reg   <= 1'b0;
            dout_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
            latch_reg    <= 1'b0;
            trim_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (ABORT) begin
                state_reg <= IDLE;
                dout_reg  <= 1'b0;
                sclk_reg  <= 1'b0;
                latch_reg <= 1'b0;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (START) begin
                            state_reg  <= LOAD;
                            code_reg   <= CODE_W'(START_CODE);
                            single_reg <= SINGLE;
                            busy_reg   <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (tick) begin
                            trim_reg    <= code_reg;
                            shreg_reg   <= code_reg;
                            bit_cnt_reg <= '0;
                            phase_reg   <= 1'b0;
                            state_reg   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            if (!phase_reg) begin
                                sclk_reg <= 1'b0;
                                if (last_bit_sent) begin
                                    latch_reg <= 1'b1;
                                    state_reg <= LATCHS;
                                end else begin
                                    dout_reg  <= out_bit;
                                    shreg_reg <= shreg_next;
                                    phase_reg <= 1'b1;
                                end
                            end else begin
                                sclk_reg    <= 1'b1;
                                bit_cnt_reg <= bit_cnt_reg + BW'(1);
                                phase_reg   <= 1'b0;
                            end
                        end
                    end
                    LATCHS: begin
                        if (tick) begin
                            latch_reg    <= 1'b0;
                            hold_cnt_reg <= '0;
                            state_reg    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            hold_cnt_reg <= hold_cnt_reg + HW'(1);
                            if (last_hold_tick) begin
                                if (sweep_end) begin
                                    state_reg <= IDLE;
                                    done_reg  <= 1'b1;
                                    busy_reg  <= 1'b0;
                                end else begin
                                    code_reg  <= next_code;
                                    state_reg <= LOAD;
                                end
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign DOUT     = dout_reg;
    assign SCLK     = sclk_reg;
    assign LATCH    = latch_reg;
    assign TRIMCODE = trim_reg;
    assign BUSY     = busy_reg;
    assign DONE     = done_reg;

endmodule

// File: tb/tb_trim_sweep_gen.sv
// Three generator configurations checked against a timeline model derived from the sweep rules.
module tb_trim_sweep_gen;

    localparam int W      = 4;
    localparam int DIVM   = 1;
    localparam int SETTLE = 2;
    localparam int T      = DIVM + 1;
    localparam int F      = 2*W + 3 + SETTLE;
    localparam int N      = 3;

    function automatic int cfg_start(input int i);
        return (i == 2) ? 10 : 3;
    endfunction
    function automatic int cfg_end(input int i);
        return (i == 2) ? 15 : 7;
    endfunction
    function automatic int cfg_step(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 3 : 1);
    endfunction
    function automatic int cfg_msb(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] start  = '0;
    logic [N-1:0] abort  = '0;
    logic [N-1:0] single = '0;
    wire  [N-1:0] dout, sclk, latch, busy, done;
    wire  [W-1:0] trim [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        trim_sweep_gen #(
            .CODE_W(W), .DIV_MAX(DIVM), .START_CODE(cfg_start(gi)), .END_CODE(cfg_end(gi)),
            .STEP(cfg_step(gi)), .SETTLE_TICKS(SETTLE), .MSB_FIRST(cfg_msb(gi))
        ) u_dut (
            .CLK50(clk), .RST_N(rst_n), .START(start[gi]), .ABORT(abort[gi]), .SINGLE(single[gi]),
            .DOUT(dout[gi]), .SCLK(sclk[gi]), .LATCH(latch[gi]), .TRIMCODE(trim[gi]),
            .BUSY(busy[gi]), .DONE(done[gi])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_codes[$];
    int last_trim[N];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Code list of one operation: START_CODE, +STEP, clamped at END_CODE, or just START_CODE.
    task automatic build_codes(input int i, input bit sgl);
        int c;
        bit fin;
        c   = cfg_start(i);
        fin = 1'b0;
        exp_codes.delete();
        while (!fin) begin
            exp_codes.push_back(c);
            if (sgl || c == cfg_end(i)) fin = 1'b1;
            else c = (c + cfg_step(i) > cfg_end(i)) ? cfg_end(i) : c + cfg_step(i);
        end
    endtask

    function automatic int exp_bit(input int i, input int code, input int n);
        return (cfg_msb(i) != 0) ? ((code >> (W-1-n)) & 1) : ((code >> n) & 1);
    endfunction

    task automatic run_op(input int i, input bit sgl, input int abort_off,
                          input int start_hold, input bit keep_start);
        int n, e0, done_edge, abort_edge, k_latch, dones, loads, lrise, exp_trim;
        int bits[$];
        bit ps, pl, aborted;
        build_codes(i, sgl);
        n = exp_codes.size();
        start[i]  = 1'b1;
        single[i] = sgl;
        step();
        e0 = cyc;
        check("busy_rise", busy[i], 1);
        done_edge  = e0 + T*n*F;
        abort_edge = (abort_off > 0) ? e0 + abort_off : -1;
        ps = sclk[i]; pl = latch[i];
        k_latch = 0; dones = 0; aborted = 1'b0; lrise = 0;
        bits.delete();
        for (int t = 0; t < n*F*T + 6; t++) begin
            if (!keep_start && (cyc - e0) >= start_hold) start[i] = 1'b0;
            if (cyc + 1 == abort_edge) begin
                abort[i] = 1'b1;
                start[i] = 1'b0;
            end
            step();
            if (cyc == abort_edge) begin
                abort[i] = 1'b0;
                aborted  = 1'b1;
                check("abort_sclk", sclk[i], 0);
                check("abort_dout", dout[i], 0);
                check("abort_latch", latch[i], 0);
                check("abort_busy", busy[i], 0);
                check("abort_done", done[i], 0);
                loads = 0;
                for (int k = 0; k < n; k++)
                    if (e0 + T + k*F*T < abort_edge) loads = k + 1;
                exp_trim = (loads > 0) ? exp_codes[loads-1] : last_trim[i];
                check("abort_trim", trim[i], exp_trim);
                last_trim[i] = exp_trim;
                break;
            end
            if (sclk[i] && !ps) bits.push_back(int'(dout[i]));
            if (latch[i] && !pl) begin
                if (k_latch < n) begin
                    check("latch_time", cyc, e0 + T + k_latch*F*T + T*(2*W+1));
                    check("latch_code", trim[i], exp_codes[k_latch]);
                    check("bit_count", bits.size(), W);
                    for (int b = 0; b < W && b < bits.size(); b++)
                        check("sclk_bit", bits[b], exp_bit(i, exp_codes[k_latch], b));
                end
                k_latch++;
                bits.delete();
                lrise = cyc;
            end
            if (!latch[i] && pl) check("latch_width", cyc - lrise, T);
            if (done[i]) begin
                dones++;
                check("done_time", cyc, done_edge);
                check("busy_at_done", busy[i], 0);
            end
            ps = sclk[i];
            pl = latch[i];
            if (cyc >= done_edge + 2) break;
        end
        if (!aborted) begin
            check("done_count", dones, 1);
            check("latch_count", k_latch, n);
            last_trim[i] = exp_codes[n-1];
            if (!keep_start) check("busy_idle", busy[i], 0);
        end else begin
            check("abort_no_done", dones, 0);
            for (int t = 0; t < 4; t++) begin
                step();
                check("abort_quiet", int'(done[i]) + int'(busy[i]), 0);
            end
        end
        single[i] = 1'b0;
    endtask

    initial begin
        int i, sgl, total, aoff, hold, e0, dcnt;
        for (int k = 0; k < N; k++) last_trim[k] = 0;
        repeat (3) step();
        for (int k = 0; k < N; k++) begin
            check("rst_trim", trim[k], 0);
            check("rst_busy", busy[k], 0);
            check("rst_outs", int'(dout[k]) + int'(sclk[k]) + int'(latch[k]) + int'(done[k]), 0);
        end
        rst_n = 1'b1;
        step();

        run_op(0, 1'b0, -1, 1, 1'b0);           // sweep 3,5,7 MSB first
        run_op(1, 1'b0, -1, 1, 1'b0);           // clamp 3,6,7
        run_op(2, 1'b1, -1, 1, 1'b0);           // single 0xA LSB first
        run_op(0, 1'b0, 2*F*T, 1, 1'b0);        // abort on final hold tick of code 5

        start[0] = 1'b1; abort[0] = 1'b1;
        step();
        check("start_abort_busy", busy[0], 0);
        start[0] = 1'b0; abort[0] = 1'b0;
        step();
        check("start_abort_idle", busy[0], 0);

        // START held through the whole sweep restarts it right after DONE
        run_op(0, 1'b0, -1, 0, 1'b1);
        check("restart_busy", busy[0], 1);
        start[0] = 1'b0;
        step();
        check("restart_code", trim[0], cfg_start(0));
        last_trim[0] = cfg_start(0);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("restart_abort_busy", busy[0], 0);

        // Asynchronous reset in the middle of a shift
        start[0] = 1'b1;
        step();
        e0 = cyc;
        start[0] = 1'b0;
        while (cyc < e0 + T + 4*T) step();
        check("mid_shift_busy", busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy[0], 0);
        check("arst_trim", trim[0], 0);
        check("arst_outs", int'(dout[0]) + int'(sclk[0]) + int'(latch[0]) + int'(done[0]), 0);
        step();
        rst_n = 1'b1;
        dcnt = 0;
        for (int t = 0; t < 40; t++) begin
            step();
            dcnt += int'(done[0]) + int'(busy[0]);
        end
        check("arst_no_done", dcnt, 0);
        for (int k = 0; k < N; k++) last_trim[k] = 0;

        for (int r = 0; r < 10; r++) begin
            i   = $urandom_range(0, N-1);
            sgl = $urandom_range(0, 1);
            build_codes(i, sgl[0]);
            total = exp_codes.size() * F * T;
            aoff  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, total) : -1;
            hold  = $urandom_range(1, total);
            run_op(i, sgl[0], aoff, hold, 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
